// File: rtl/sc_spi_scg.sv
// sc_spi_scg: SPI base clock generator with registered rise/fall strobes.
module sc_spi_scg #(
    parameter int CNT_W = 8
) (
    input  logic             SYSCLK,
    input  logic             SYSRSTB,
    input  logic             CLK_ENABLE,
    input  logic [CNT_W-1:0] CLK_WIDTH_HIGH,
    input  logic [CNT_W-1:0] CLK_WIDTH_LOW,
    output logic             SCLK_BASE,
    output logic             SCK_RISE,
    output logic             SCK_FALL,
    output logic             SCK_ACTIVE
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state      <= IDLE;
            cnt        <= '0;
            SCLK_BASE  <= 1'b0;
            SCK_RISE   <= 1'b0;
            SCK_FALL   <= 1'b0;
            SCK_ACTIVE <= 1'b0;
        end else begin
            SCK_RISE <= 1'b0;
            SCK_FALL <= 1'b0;
            if (state == IDLE) begin
                if (CLK_ENABLE) begin
                    state      <= LOW;
                    cnt        <= CLK_WIDTH_LOW;
                    SCK_ACTIVE <= 1'b1;
                end
            end else if (!CLK_ENABLE) begin
                // abort outranks phase expiry, so no strobe is emitted here
                state      <= IDLE;
                cnt        <= '0;
                SCLK_BASE  <= 1'b0;
                SCK_ACTIVE <= 1'b0;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else if (state == LOW) begin
                state     <= HIGH;
                cnt       <= CLK_WIDTH_HIGH;
                SCLK_BASE <= 1'b1;
                SCK_RISE  <= 1'b1;
            end else begin
                state     <= LOW;
                cnt       <= CLK_WIDTH_LOW;
                SCLK_BASE <= 1'b0;
                SCK_FALL  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sc_spi_scg.sv
// tb_sc_spi_scg: table-driven, directed and randomized checks of sc_spi_scg
// against a cycle-count model of the phase schedule.
module tb_sc_spi_scg;
    logic       SYSCLK = 1'b0;
    logic       SYSRSTB = 1'b0;
    logic       CLK_ENABLE = 1'b0;
    logic [7:0] CLK_WIDTH_HIGH = '0;
    logic [7:0] CLK_WIDTH_LOW = '0;
    logic       SCLK_BASE, SCK_RISE, SCK_FALL, SCK_ACTIVE;

    sc_spi_scg #(.CNT_W(8)) dut (
        .SYSCLK(SYSCLK), .SYSRSTB(SYSRSTB), .CLK_ENABLE(CLK_ENABLE),
        .CLK_WIDTH_HIGH(CLK_WIDTH_HIGH), .CLK_WIDTH_LOW(CLK_WIDTH_LOW),
        .SCLK_BASE(SCLK_BASE), .SCK_RISE(SCK_RISE), .SCK_FALL(SCK_FALL),
        .SCK_ACTIVE(SCK_ACTIVE)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_chk = 0;
    int n_fail = 0;

    // reference: phase position counted up against a phase length fixed at entry
    bit m_act, m_lvl, m_rise, m_fall;
    int m_age, m_len;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_age = 0; m_len = 0;
    endtask

    task automatic model_step(input bit en, input int wh, input int wl);
        m_rise = 0;
        m_fall = 0;
        if (!m_act) begin
            if (en) begin
                m_act = 1; m_lvl = 0; m_len = wl + 1; m_age = 1;
            end
        end else if (!en) begin
            m_act = 0; m_lvl = 0;
        end else if (m_age == m_len) begin
            m_lvl  = !m_lvl;
            m_rise = m_lvl;
            m_fall = !m_lvl;
            m_len  = (m_lvl ? wh : wl) + 1;
            m_age  = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic tick();
        bit en;
        int wh, wl;
        en = CLK_ENABLE; wh = CLK_WIDTH_HIGH; wl = CLK_WIDTH_LOW;
        @(posedge SYSCLK);
        model_step(en, wh, wl);
        @(negedge SYSCLK);
        check("sclk_base", SCLK_BASE, m_lvl);
        check("sck_rise", SCK_RISE, m_rise);
        check("sck_fall", SCK_FALL, m_fall);
        check("sck_active", SCK_ACTIVE, m_act);
        check("no_overlap", SCK_RISE & SCK_FALL, 0);
    endtask

    task automatic wait_strobe(input bit fall, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(fall ? SCK_FALL : SCK_RISE) && n < 2000);
    endtask

    task automatic go_idle();
        CLK_ENABLE = 0;
        tick();
        tick();
    endtask

    typedef struct {
        int wh, wl;
        int first_rise, fall_off, period;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int n, m;
        vecs[0] = '{2, 3, 5, 3, 7};
        vecs[1] = '{0, 0, 2, 1, 2};
        vecs[2] = '{1, 4, 6, 2, 7};
        vecs[3] = '{7, 0, 2, 8, 9};
        vecs[4] = '{255, 255, 257, 256, 512};
        model_reset();
        #12;
        check("reset_base", SCLK_BASE, 0);
        check("reset_rise", SCK_RISE, 0);
        check("reset_fall", SCK_FALL, 0);
        check("reset_active", SCK_ACTIVE, 0);
        @(negedge SYSCLK);
        SYSRSTB = 1;
        tick();

        foreach (vecs[i]) begin
            go_idle();
            CLK_WIDTH_HIGH = 8'(vecs[i].wh);
            CLK_WIDTH_LOW  = 8'(vecs[i].wl);
            CLK_ENABLE = 1;
            wait_strobe(0, n);
            check($sformatf("first_rise[%0d]", i), n, vecs[i].first_rise);
            wait_strobe(1, n);
            check($sformatf("fall_off[%0d]", i), n, vecs[i].fall_off);
            wait_strobe(0, m);
            check($sformatf("period[%0d]", i), n + m, vecs[i].period);
        end

        // min widths: strobes alternate every cycle
        go_idle();
        CLK_WIDTH_HIGH = 0; CLK_WIDTH_LOW = 0; CLK_ENABLE = 1;
        wait_strobe(0, n);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("alt_fall", SCK_FALL, (k % 2 == 0) ? 1 : 0);
            check("alt_rise", SCK_RISE, (k % 2 == 1) ? 1 : 0);
        end

        // async reset mid-HIGH, then restart timing
        go_idle();
        CLK_WIDTH_HIGH = 2; CLK_WIDTH_LOW = 3; CLK_ENABLE = 1;
        wait_strobe(0, n);
        tick();
        SYSRSTB = 0;
        #1;
        check("rst_mid_base", SCLK_BASE, 0);
        check("rst_mid_active", SCK_ACTIVE, 0);
        check("rst_mid_rise", SCK_RISE, 0);
        check("rst_mid_fall", SCK_FALL, 0);
        model_reset();
        #2 SYSRSTB = 1;
        wait_strobe(0, n);
        check("rst_restart_rise", n, 5);

        // abort in the cycle the HIGH counter reaches 0
        tick();
        tick();
        CLK_ENABLE = 0;
        tick();
        check("abort_fall", SCK_FALL, 0);
        check("abort_base", SCLK_BASE, 0);
        check("abort_active", SCK_ACTIVE, 0);

        // width change during a high phase takes effect next phase
        tick();
        CLK_WIDTH_HIGH = 5; CLK_WIDTH_LOW = 1; CLK_ENABLE = 1;
        wait_strobe(0, n);
        tick();
        CLK_WIDTH_HIGH = 1;
        wait_strobe(1, n);
        check("hi_len_old", n + 1, 6);
        wait_strobe(0, n);
        wait_strobe(1, n);
        check("hi_len_new", n, 2);

        // randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) CLK_ENABLE = !CLK_ENABLE;
            if ($urandom_range(0, 15) == 0) CLK_WIDTH_HIGH = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) CLK_WIDTH_LOW = 8'($urandom_range(0, 7));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
